// File: rtl/weight_fetch_unit.sv
// Purpose : streams MUL_SIZE-byte weight rows from a fixed-latency memory into a row FIFO for the systolic array.
// Latency : first read issues the cycle after start is accepted; a row is poppable MEM_LAT+1 cycles after its read issues.
// Backpr. : reads issue only while FIFO occupancy plus reads in flight is below DEPTH, so returned data is never dropped.
//
// Ports
//   clk_i, rst_i          clock (rising edge) and synchronous active-high reset
//   start_i               one-cycle job request, accepted only while busy_o=0
//   base_addr_i           first weight row address of the job
//   U_dim_i, ITER_dim_i   matrix dimensions; rows = (U>>5)*(ITER>>5)*MUL_SIZE
//   mem_rd_en_o/addr_o    weight memory read request
//   mem_rdata_i           read data, valid exactly MEM_LAT cycles after the request
//   weight_row_o          FIFO head row, read combinationally from storage
//   weight_fifo_valid_o   FIFO holds at least one row
//   pop_i                 consumer takes the head row this cycle (ignored when empty)
//   busy_o, done_o        job in progress / one-cycle end-of-job pulse
//   underflow_err_o,occ_o only with WEIGHT_FETCH_ERR_EN: sticky pop-while-empty flag and live occupancy
//
// Optional feature macro: WEIGHT_FETCH_ERR_EN

module weight_fetch_unit #(
    parameter int MUL_SIZE = 32,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 16,
    parameter int MEM_LAT  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [7:0]              U_dim_i,
    input  logic [7:0]              ITER_dim_i,
    output logic                    mem_rd_en_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    input  logic [8*MUL_SIZE-1:0]   mem_rdata_i,
    output logic [8*MUL_SIZE-1:0]   weight_row_o,
    output logic                    weight_fifo_valid_o,
    input  logic                    pop_i,
    output logic                    busy_o,
    output logic                    done_o
`ifdef WEIGHT_FETCH_ERR_EN
    ,
    output logic                    underflow_err_o,
    output logic [$clog2(DEPTH):0]  occ_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = 8 * MUL_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic [12:0]         rows_left_q;
    logic [MEM_LAT-1:0]  vld_sr;
    logic [PW:0]         inflight;

    logic [7:0]          u_tiles;
    logic [7:0]          it_tiles;
    logic [12:0]         total_rows;

    logic                start_acc;
    logic                issue;
    logic                busy;
    logic                done;
    logic                credit_ok;

    logic [RW-1:0]       store [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         occ;
    logic                wr_en;
    logic                pop_en;

    // ------------------------------------------------------------------
    // Job sizing: tile counts come from the dimensions in 32-element
    // units; the product always fits in 13 bits for 8-bit dimensions.
    // ------------------------------------------------------------------
    assign u_tiles    = U_dim_i >> 5;
    assign it_tiles   = ITER_dim_i >> 5;
    assign total_rows = 13'(32'(u_tiles) * 32'(it_tiles) * MUL_SIZE);

    // Reads in flight = valid bits still travelling through the memory
    // latency pipe; the oldest bit marks the data arriving this cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + (PW+1)'(vld_sr[i]);
        end
    end

    // Credit: every issued read owns a FIFO slot until it is popped.
    assign credit_ok = ({1'b0, occ} + {1'b0, inflight}) < (PW+2)'(DEPTH);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = (total_rows == 13'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (credit_ok) begin
                    issue = 1'b1;
                    // Leave FETCH in the same cycle the final read goes out.
                    if (rows_left_q == 13'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (inflight == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                // busy_o is already low here, so a new request is honoured.
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = (total_rows == 13'd0) ? DONE : FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / row counters and memory latency tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            rows_left_q <= '0;
            // Clearing the pipe discards any read data still in flight.
            vld_sr      <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | MEM_LAT'(issue);
            if (start_acc) begin
                addr_q      <= base_addr_i;
                rows_left_q <= total_rows;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_W'(1);
                rows_left_q <= rows_left_q - 13'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row FIFO
    // ------------------------------------------------------------------
    assign wr_en  = vld_sr[MEM_LAT-1];
    assign pop_en = pop_i && (occ != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop_en})
                2'b10:   occ <= occ + (PW+1)'(1);
                2'b01:   occ <= occ - (PW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; rows are only observable through occ.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            store[wr_ptr] <= mem_rdata_i;
        end
    end

    assign weight_row_o = store[rd_ptr];

    // ------------------------------------------------------------------
    // Outputs: forced quiet while reset is asserted, even before the
    // first reset edge has cleared the state.
    // ------------------------------------------------------------------
    assign mem_rd_en_o         = issue && !rst_i;
    assign mem_addr_o          = rst_i ? '0 : addr_q;
    assign weight_fifo_valid_o = (occ != '0) && !rst_i;
    assign busy_o              = busy && !rst_i;
    assign done_o              = done && !rst_i;

`ifdef WEIGHT_FETCH_ERR_EN
    logic underflow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underflow_q <= 1'b0;
        end else if (pop_i && (occ == '0)) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow_err_o = underflow_q;
    assign occ_o           = occ;
`endif

endmodule
